// File: rtl/mem_access_ctrl.sv
// Load/store bus sequencer: one outstanding access, byte-lane steering, wait timeout.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of truncating lanes.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct_3,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] Read_Data_mem,
   output logic        rsp_valid,
   output logic        stall,
   output logic        bus_err,
   output logic        misalign_trap,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);

   state_e      state_q;
   logic [9:0]  wait_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        is_load_q;
   logic        mem_valid_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] rdata_q;
   logic        rsp_valid_q;
   logic        bus_err_q;
   logic        trap_q;

   logic        is_load_d;
   logic        is_store_d;
   logic        legal_d;
   logic        misalign_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] rdata_d;

   always_comb begin
      is_load_d  = (opcode == 7'h03);
      is_store_d = (opcode == 7'h23);
      legal_d    = (is_load_d && (funct_3 != 3'd3) && (funct_3 != 3'd6) && (funct_3 != 3'd7)) ||
                   (is_store_d && !funct_3[2] && (funct_3[1:0] != 2'd3));
      case (funct_3[1:0])
         2'd0: begin
            be_d    = 4'b0001 << Address[1:0];
            wdata_d = {4{Write_Data[7:0]}};
         end
         2'd1: begin
            be_d    = 4'b0011 << {Address[1], 1'b0};
            wdata_d = {2{Write_Data[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = Write_Data;
         end
      endcase
      // Only the lane shift happens here; sign/zero extension belongs to the formatter.
      case (size_q)
         2'd0:    rdata_d = mem_rdata >> {lane_q, 3'b000};
         2'd1:    rdata_d = mem_rdata >> {lane_q[1], 4'b0000};
         default: rdata_d = mem_rdata;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign misalign_d = ((funct_3[1:0] == 2'd1) && Address[0]) ||
                       ((funct_3[1:0] == 2'd2) && (Address[1:0] != 2'd0));
`else
   assign misalign_d = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         size_q      <= '0;
         lane_q      <= '0;
         is_load_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
         trap_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  is_load_q <= is_load_d;
                  size_q    <= funct_3[1:0];
                  lane_q    <= Address[1:0];
                  if (!legal_d) begin
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rdata_q     <= '0;
                  end else if (misalign_d) begin
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     trap_q      <= 1'b1;
                  end else begin
                     state_q     <= ACCESS;
                     mem_valid_q <= 1'b1;
                     mem_we_q    <= is_store_d;
                     mem_addr_q  <= {Address[31:2], 2'b00};
                     mem_be_q    <= be_d;
                     mem_wdata_q <= wdata_d;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  state_q     <= DONE;
                  mem_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  if (is_load_q) begin
                     rdata_q <= rdata_d;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  state_q     <= DONE;
                  mem_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  bus_err_q   <= 1'b1;
               end else begin
                  wait_q <= wait_q + 10'd1;
               end
            end
            DONE: begin
               state_q     <= IDLE;
               wait_q      <= '0;
               rsp_valid_q <= 1'b0;
               bus_err_q   <= 1'b0;
               trap_q      <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign stall         = req_valid & ~rsp_valid_q;
   assign mem_valid     = mem_valid_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_be        = mem_be_q;
   assign mem_wdata     = mem_wdata_q;
   assign Read_Data_mem = rdata_q;
   assign rsp_valid     = rsp_valid_q;
   assign bus_err       = bus_err_q;
   assign misalign_trap = trap_q;
   assign dbg_state_o   = state_q;

endmodule
